// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Contents: access-size enum, FSM state encodings (plain localparams), byte-mask base
// patterns and the misalignment predicate used when LSU_MISALIGN_CHECK_EN is defined.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StAccess = 2'd1;
  localparam state_t StWait   = 2'd2;
  localparam state_t StResp   = 2'd3;

  localparam logic [3:0] MaskByte = 4'b0001;
  localparam logic [3:0] MaskHalf = 4'b0011;
  localparam logic [3:0] MaskWord = 4'b1111;

  // Size code 2'b11 behaves as a word, so size[1] selects "word" here.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] off);
    return ((size == SZ_H) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the LSU request, response and sram-side signals.
// slave  : view of the LSU itself (takes requests, returns results, drives sram strobes).
// master : view of the surrounding logic (execute stage, write-back stage and sram).
interface lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_ren;
  logic        in_wen;
  logic [1:0]  in_size;
  logic        in_signed;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_err;

  logic        sram_ren;
  logic        sram_wen;
  logic [7:0]  sram_wmask;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_data;

  modport slave (
    input  in_valid, in_ren, in_wen, in_size, in_signed, in_addr, in_wdata, in_rd,
    output in_ready,
    output out_valid, out_rdata, out_rd, out_err,
    input  out_ready,
    output sram_ren, sram_wen, sram_wmask, sram_addr, sram_wdata,
    input  sram_data
  );

  modport master (
    output in_valid, in_ren, in_wen, in_size, in_signed, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  out_valid, out_rdata, out_rd, out_err,
    output out_ready,
    input  sram_ren, sram_wen, sram_wmask, sram_addr, sram_wdata,
    output sram_data
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment for the LSU.
// size_i/signed_i/off_i : access descriptor (off_i = addr[1:0])
// wdata_i -> wmask_o, wdata_o : store byte enables and lane-shifted store data
// rdata_i -> rdata_o          : load data extracted and zero/sign extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  shamt;
  logic [31:0] rsh;

  assign shamt = {off_i, 3'b000};
  assign rsh   = rdata_i >> shamt;

  // Words ignore the offset entirely (silently aligned down); shifted masks are
  // truncated to 4 bits, so a half at offset 3 only touches byte 3.
  always_comb begin
    wmask_o = MaskWord;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    if (size_i == SZ_B) begin
      wmask_o = MaskByte << off_i;
      wdata_o = {24'h0, wdata_i[7:0]} << shamt;
      rdata_o = {{24{signed_i & rsh[7]}}, rsh[7:0]};
    end else if (size_i == SZ_H) begin
      wmask_o = MaskHalf << off_i;
      wdata_o = {16'h0, wdata_i[15:0]} << shamt;
      rdata_o = {{16{signed_i & rsh[15]}}, rsh[15:0]};
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of a combinational sram port.
// clk_i, rst_ni : clock and asynchronous active-low reset
// bus (slave)   : request handshake (in_*), result handshake (out_*), sram strobes/data
// MEM_LAT       : cycles sram_ren is held per load (>= 1); data sampled on the last one
// Optional: define LSU_MISALIGN_CHECK_EN to turn misaligned half/word accesses into
// strobe-free error responses (out_err = 1); otherwise out_err stays 0.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input logic  clk_i,
  input logic  rst_ni,
  lsu_if.slave bus
);

  localparam int unsigned     CntW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic              err_q, err_d;
  logic [4:0]        rd_q, rd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              misalign;
  logic              is_load;
  logic              accept;
  logic              in_access;
  logic [3:0]        wmask_al;
  logic [31:0]       wdata_al;
  logic [31:0]       rdata_al;

  lsu_align u_align (
    .size_i   (size_q),
    .signed_i (signed_q),
    .off_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (bus.sram_data),
    .wmask_o  (wmask_al),
    .wdata_o  (wdata_al),
    .rdata_o  (rdata_al)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(size_q, addr_q[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // A request with both ren and wen is a store.
  assign is_load   = ren_q & ~wen_q;
  assign accept    = bus.in_valid & in_ready_q;
  assign in_access = (state_q == StAccess);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    size_d   = size_q;
    signed_d = signed_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    err_d    = err_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d   = bus.in_addr;
          wdata_d  = bus.in_wdata;
          size_d   = bus.in_size;
          signed_d = bus.in_signed;
          ren_d    = bus.in_ren;
          wen_d    = bus.in_wen;
          rd_d     = bus.in_rd;
          rdata_d  = 32'h0;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = (bus.in_ren | bus.in_wen) ? StAccess : StResp;
        end
      end
      StAccess: begin
        if (misalign) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else if (wen_q) begin
          state_d = StResp;
        end else if (MEM_LAT == 1) begin
          rdata_d = rdata_al;
          state_d = StResp;
        end else begin
          cnt_d   = CntW'(1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == CntLast) begin
          rdata_d = rdata_al;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    in_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= 5'h0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  // The sram writes whenever wen is high, so strobes exist only in ACCESS/WAIT.
  assign bus.sram_ren   = (in_access | (state_q == StWait)) & is_load & ~misalign;
  assign bus.sram_wen   = in_access & wen_q & ~misalign;
  assign bus.sram_wmask = bus.sram_wen ? {4'h0, wmask_al} : 8'h00;
  assign bus.sram_addr  = {addr_q[31:2], 2'b00};
  assign bus.sram_wdata = wdata_al;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == StResp);
  assign bus.out_rdata = rdata_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a transaction-level model (byte-lane memory plus timing
// rules) predicts every output on every cycle; directed cases pin the model with literals.
module tb_lsu;
  localparam int unsigned MEM_LAT = 3;

  logic clk;
  logic rst_ni;
  lsu_if bus ();

  lsu #(.MEM_LAT(MEM_LAT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  task automatic timeout_fail(string name);
    n_checks++;
    $display("FAIL %s: got no handshake expected handshake at %0t", name, $time);
  endtask

  // Stand-in sram: combinational read, byte-masked write on the clock edge.
  logic [31:0] sram_mem [16];
  assign bus.sram_data = sram_mem[bus.sram_addr[5:2]];
  always @(posedge clk) begin
    if (bus.sram_wen) begin
      for (int j = 0; j < 4; j++) begin
        if (bus.sram_wmask[j]) sram_mem[bus.sram_addr[5:2]][8*j +: 8] <= bus.sram_wdata[8*j +: 8];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] mdl_mem [16];

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input int off, input int sz,
                                           input bit sgn);
    logic [31:0] b0, b1, r;
    b0 = (w >> (8 * off)) & 32'hFF;
    b1 = (off < 3) ? ((w >> (8 * (off + 1))) & 32'hFF) : 32'h0;
    if (sz == 0) begin
      r = b0;
      if (sgn && r[7]) r = r | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      r = b0 | (b1 << 8);
      if (sgn && r[15]) r = r | 32'hFFFF_0000;
    end else begin
      r = w;
    end
    return r;
  endfunction

  function automatic void mdl_store(input logic [31:0] d, input int off, input int sz,
                                    output logic [3:0] m, output logic [31:0] w);
    m = 4'h0;
    w = 32'h0;
    for (int j = 0; j < 4; j++) begin
      bit hit;
      int src;
      if (sz >= 2) begin
        hit = 1'b1;
        src = j;
      end else if (sz == 1) begin
        hit = (j == off) || (j == off + 1);
        src = j - off;
      end else begin
        hit = (j == off);
        src = 0;
      end
      if (hit) begin
        m[j] = 1'b1;
        w[8*j +: 8] = d[8*src +: 8];
      end
    end
  endfunction

  bit seen_edge;
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) seen_edge <= 1'b0;
    else seen_edge <= 1'b1;
  end

  bit          busy;
  int          k;
  bit          t_load, t_store, t_mis;
  int          t_resp_k;
  logic [3:0]  t_mask;
  logic [31:0] t_wdata, t_saddr, t_rdata;
  logic [4:0]  t_rd;
  int          ren_cnt, wen_cnt;
  logic [7:0]  last_mask;
  logic [31:0] last_swdata, last_saddr, last_rdata;
  logic [4:0]  last_rd;
  logic        last_err;

  initial begin
    busy = 1'b0;
    k = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        busy = 1'b0;
      end else begin : cmp
        bit exp_rdy, exp_ren, exp_wen, exp_val;
        logic [7:0] exp_mask;
        exp_rdy  = !busy && seen_edge;
        exp_ren  = busy && t_load && !t_mis && k >= 1 && k <= int'(MEM_LAT);
        exp_wen  = busy && t_store && !t_mis && k == 1;
        exp_val  = busy && k >= t_resp_k;
        exp_mask = exp_wen ? {4'h0, t_mask} : 8'h00;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(exp_val));
        check("sram_ren", 32'(bus.sram_ren), 32'(exp_ren));
        check("sram_wen", 32'(bus.sram_wen), 32'(exp_wen));
        check("sram_wmask", 32'(bus.sram_wmask), 32'(exp_mask));
        if (bus.sram_ren) ren_cnt++;
        if (bus.sram_wen) begin
          wen_cnt++;
          last_mask   = bus.sram_wmask;
          last_swdata = bus.sram_wdata;
          last_saddr  = bus.sram_addr;
        end
        if (exp_ren || exp_wen) check("sram_addr", bus.sram_addr, t_saddr);
        if (exp_wen) check("sram_wdata", bus.sram_wdata, t_wdata);
        if (exp_val) begin
          check("out_rdata", bus.out_rdata, t_rdata);
          check("out_rd", 32'(bus.out_rd), 32'(t_rd));
          check("out_err", 32'(bus.out_err), 32'(t_mis));
          if (bus.out_ready) begin
            busy       = 1'b0;
            last_rdata = bus.out_rdata;
            last_rd    = bus.out_rd;
            last_err   = bus.out_err;
          end
        end
        if (busy) begin
          k++;
        end else if (exp_rdy && bus.in_valid) begin : acc
          int off, sz;
          bit noop;
          off     = int'(bus.in_addr[1:0]);
          sz      = int'(bus.in_size);
          t_store = bus.in_wen;
          t_load  = bus.in_ren && !bus.in_wen;
          noop    = !bus.in_ren && !bus.in_wen;
`ifdef LSU_MISALIGN_CHECK_EN
          t_mis = !noop && ((sz == 1 && off % 2 == 1) || (sz >= 2 && off != 0));
`else
          t_mis = 1'b0;
`endif
          t_resp_k = noop ? 1 : ((t_load && !t_mis) ? int'(MEM_LAT) + 1 : 2);
          t_saddr  = bus.in_addr & ~32'h3;
          t_rd     = bus.in_rd;
          mdl_store(bus.in_wdata, off, sz, t_mask, t_wdata);
          if (t_store && !t_mis) begin
            for (int j = 0; j < 4; j++) begin
              if (t_mask[j]) mdl_mem[bus.in_addr[5:2]][8*j +: 8] = t_wdata[8*j +: 8];
            end
          end
          t_rdata = (t_load && !t_mis) ?
                    mdl_load(mdl_mem[bus.in_addr[5:2]], off, sz, bus.in_signed) : 32'h0;
          busy    = 1'b1;
          k       = 1;
          ren_cnt = 0;
          wen_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // mode 0: out_ready high; 1: out_ready low for `hold` valid cycles; 2: random out_ready
  task automatic issue(input bit r, input bit w, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input int mode, input int hold);
    bit got, done;
    int vcnt;
    bus.in_ren    = r;
    bus.in_wen    = w;
    bus.in_size   = sz;
    bus.in_signed = sg;
    bus.in_addr   = a;
    bus.in_wdata  = d;
    bus.in_rd     = rd;
    bus.in_valid  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!got) begin
      timeout_fail("accept_timeout");
      return;
    end
    done = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (vcnt >= hold);
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      if (bus.out_valid) begin
        if (bus.out_ready) done = 1'b1;
        else vcnt++;
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    if (!done) timeout_fail("resp_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_ren    = 1'b0;
    bus.in_wen    = 1'b0;
    bus.in_size   = 2'b00;
    bus.in_signed = 1'b0;
    bus.in_addr   = 32'h0;
    bus.in_wdata  = 32'h0;
    bus.in_rd     = 5'h0;
    bus.out_ready = 1'b1;
    rst_ni = 1'b0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_sram_ren", 32'(bus.sram_ren), 0);
    check("rst_sram_wen", 32'(bus.sram_wen), 0);
    check("rst_sram_wmask", 32'(bus.sram_wmask), 0);
    check("rst_sram_addr", bus.sram_addr, 0);
    check("rst_out_rdata", bus.out_rdata, 0);
    check("rst_out_err", 32'(bus.out_err), 0);
    #2 rst_ni = 1'b1;
    #1 check("rel_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;

    // Give every sram word a defined value through the DUT itself.
    for (int i = 0; i < 16; i++)
      issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0000 + 32'(4 * i), $urandom, 5'd0, 0, 0);

    // Word store
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 5'd1, 0, 0);
    check("ws_wen_cycles", 32'(wen_cnt), 1);
    check("ws_wmask", 32'(last_mask), 32'h0F);
    check("ws_addr", last_saddr, 32'h8000_0004);
    check("ws_wdata", last_swdata, 32'hDEAD_BEEF);
    check("ws_rdata", last_rdata, 0);

    // Byte store at offset 3
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h8000_0003, 32'h0000_00AB, 5'd2, 0, 0);
    check("bs_wmask", 32'(last_mask), 32'h08);
    check("bs_wdata", last_swdata, 32'hAB00_0000);

    // Byte loads, signed and unsigned
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h0080_0000, 5'd3, 0, 0);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h8000_0002, 32'h0, 5'd5, 0, 0);
    check("lbs_rdata", last_rdata, 32'hFFFF_FF80);
    check("lbs_rd", 32'(last_rd), 5);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h8000_0002, 32'h0, 5'd6, 0, 0);
    check("lbu_rdata", last_rdata, 32'h0000_0080);

    // Signed half load, offset 2, multi-cycle read
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0008, 32'h8001_1234, 5'd3, 0, 0);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h8000_000A, 32'h0, 5'd8, 0, 0);
    check("lh_ren_cycles", 32'(ren_cnt), MEM_LAT);
    check("lh_rdata", last_rdata, 32'hFFFF_8001);

    // Back-pressure: result held for 5 cycles
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'h0, 5'd9, 1, 5);
    check("bp_rdata", last_rdata, 32'hDEAD_BEEF);
    check("bp_rd", 32'(last_rd), 9);

    // No-op request
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'h1234_5678, 5'd7, 0, 0);
    check("nop_rdata", last_rdata, 0);
    check("nop_strobes", 32'(ren_cnt + wen_cnt), 0);

    // Misaligned word load and half store at offset 3
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0001, 32'h0, 5'd10, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mw_ren_cycles", 32'(ren_cnt), 0);
    check("mw_err", 32'(last_err), 1);
    check("mw_rdata", last_rdata, 0);
`else
    check("mw_ren_cycles", 32'(ren_cnt), MEM_LAT);
    check("mw_err", 32'(last_err), 0);
    check("mw_rdata", last_rdata, 32'h0080_0000);
`endif
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h8000_0007, 32'h0000_5566, 5'd11, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("hs3_wen_cycles", 32'(wen_cnt), 0);
    check("hs3_err", 32'(last_err), 1);
`else
    check("hs3_wmask", 32'(last_mask), 32'h08);
    check("hs3_wdata", last_swdata, 32'h6600_0000);
`endif

    // Reset during ACCESS of a load
    bus.in_ren    = 1'b1;
    bus.in_wen    = 1'b0;
    bus.in_size   = 2'b10;
    bus.in_signed = 1'b0;
    bus.in_addr   = 32'h8000_0004;
    bus.in_rd     = 5'd12;
    bus.in_valid  = 1'b1;
    begin : rst_acc
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (bus.in_ready) got = 1'b1;
      end
      if (!got) timeout_fail("rst_accept_timeout");
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_ren", 32'(bus.sram_ren), 1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_ren_drop", 32'(bus.sram_ren), 0);
    check("rst_wen_drop", 32'(bus.sram_wen), 0);
    check("rst_valid_drop", 32'(bus.out_valid), 0);
    repeat (2) @(negedge clk);
    #2 rst_ni = 1'b1;
    #1 check("rst_rel_in_ready", 32'(bus.in_ready), 0);
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int sel;
      bit r, w;
      sel = $urandom_range(0, 9);
      r = (sel <= 3) || (sel == 8);
      w = (sel >= 4 && sel <= 8);
      issue(r, w, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'h8000_0000 + 32'($urandom_range(0, 63)), $urandom, 5'($urandom_range(0, 31)),
            2, 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
